// File: rtl/xor_encryptor.sv
// Single-word XOR cipher engine: captures data/key on start, then presents
// data ^ key on data_out with a one-cycle done pulse.
module xor_encryptor #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] key_in,
   output logic [WIDTH-1:0] data_out,
   output logic             done,
   output logic [1:0]       state_dbg
);

   // Control handshake: start is a request sampled only while IDLE; when it is
   // seen at an edge the inputs are captured (accepted) and any start seen in
   // ENCRYPTING or DONE is dropped, not queued. done is a one-cycle completion
   // strobe and data_out then holds the result until the next one or reset.
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ENCRYPTING = 2'd1,
      DONE       = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             capture;
   logic [WIDTH-1:0] data_reg;
   logic [WIDTH-1:0] key_reg;

   assign state_dbg = state_q;

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               capture = 1'b1;
               state_d = ENCRYPTING;
            end
         end
         ENCRYPTING: state_d = DONE;
         DONE:       state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         data_reg <= '0;
         key_reg  <= '0;
         data_out <= '0;
         done     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            data_reg <= data_in;
            key_reg  <= key_in;
         end
         // done is high exactly while the FSM sits in DONE.
         if (state_q == ENCRYPTING) begin
            data_out <= data_reg ^ key_reg;
            done     <= 1'b1;
         end else begin
            done     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_xor_encryptor.sv
// Directed bench for xor_encryptor: reset, basic and back-to-back operations,
// input capture, ignored starts and reset in the middle of an operation.
module tb_xor_encryptor;

   localparam int WIDTH = 32;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] key_in;
   logic [WIDTH-1:0] data_out;
   logic             done;
   logic [1:0]       state_dbg;

   int checks = 0;
   int errors = 0;

   xor_encryptor #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .data_in   (data_in),
      .key_in    (key_in),
      .data_out  (data_out),
      .done      (done),
      .state_dbg (state_dbg)
   );

   // clock block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one rising edge and settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [31:0] exp_data,
                                input logic exp_done, input logic [1:0] exp_state);
      check({tag, "_data"},  data_out,          exp_data);
      check({tag, "_done"},  {31'd0, done},     {31'd0, exp_done});
      check({tag, "_state"}, {30'd0, state_dbg}, {30'd0, exp_state});
   endtask

   initial begin
      // 1. reset held: outputs stay cleared whatever start/clk do
      rst_n   = 1'b0;
      start   = 1'b1;
      data_in = 32'h1357_9bdf;
      key_in  = 32'h2468_ace0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_outputs("reset_hold", 32'h0, 1'b0, 2'd0);
      end
      rst_n = 1'b1;
      start = 1'b0;
      tick();
      check_outputs("reset_release", 32'h0, 1'b0, 2'd0);

      // 2. basic operation
      data_in = 32'hdead_beef;
      key_in  = 32'h1234_5678;
      start   = 1'b1;
      tick();
      start = 1'b0;
      check_outputs("basic_enc", 32'h0, 1'b0, 2'd1);
      tick();
      check_outputs("basic_done", 32'hcc99_e897, 1'b1, 2'd2);
      tick();
      check_outputs("basic_idle", 32'hcc99_e897, 1'b0, 2'd0);

      // 3. back-to-back: start in the cycle right after done falls
      data_in = 32'h0123_4567;
      key_in  = 32'habcd_ef01;
      start   = 1'b1;
      tick();
      start = 1'b0;
      check_outputs("b2b_enc", 32'hcc99_e897, 1'b0, 2'd1);
      tick();
      check_outputs("b2b_done", 32'haaee_aa66, 1'b1, 2'd2);
      tick();
      check_outputs("b2b_idle", 32'haaee_aa66, 1'b0, 2'd0);

      // 4. inputs changed after capture do not affect the result
      data_in = 32'hdead_beef;
      key_in  = 32'h1234_5678;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      data_in = 32'hffff_ffff;
      key_in  = 32'h0000_0000;
      tick();
      check_outputs("capture_done", 32'hcc99_e897, 1'b1, 2'd2);
      tick();
      check_outputs("capture_idle", 32'hcc99_e897, 1'b0, 2'd0);

      // 5. start during ENCRYPTING and DONE is ignored
      data_in = 32'haaaa_aaaa;
      key_in  = 32'h5555_5555;
      start   = 1'b1;
      tick();
      data_in = 32'h0000_0000;
      key_in  = 32'h0000_0000;
      tick();
      check_outputs("ignore_done", 32'hffff_ffff, 1'b1, 2'd2);
      data_in = 32'h1111_1111;
      tick();
      start = 1'b0;
      check_outputs("ignore_idle", 32'hffff_ffff, 1'b0, 2'd0);
      tick();
      check_outputs("ignore_no_op", 32'hffff_ffff, 1'b0, 2'd0);
      tick();
      check_outputs("ignore_no_pulse", 32'hffff_ffff, 1'b0, 2'd0);

      // 6. reset dropped while ENCRYPTING clears immediately, no result
      data_in = 32'hdead_beef;
      key_in  = 32'h1234_5678;
      start   = 1'b1;
      tick();
      start = 1'b0;
      check_outputs("midrst_enc", 32'hffff_ffff, 1'b0, 2'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs("midrst_async", 32'h0, 1'b0, 2'd0);
      tick();
      check_outputs("midrst_held", 32'h0, 1'b0, 2'd0);
      rst_n = 1'b1;
      tick();
      check_outputs("midrst_after", 32'h0, 1'b0, 2'd0);
      tick();
      check_outputs("midrst_no_done", 32'h0, 1'b0, 2'd0);

      // operation after recovery
      data_in = 32'h0123_4567;
      key_in  = 32'habcd_ef01;
      start   = 1'b1;
      tick();
      start = 1'b0;
      check_outputs("recover_enc", 32'h0, 1'b0, 2'd1);
      tick();
      check_outputs("recover_done", 32'haaee_aa66, 1'b1, 2'd2);
      tick();
      check_outputs("recover_idle", 32'haaee_aa66, 1'b0, 2'd0);

      // final report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
